wallace_mult_pipe: RTL
======================

# wallace_mult_pipe

- Parametrised, pipelined Wallace-tree multiplier for WIDTH×WIDTH operands with a 2·WIDTH-bit product.
- Accepts one operand pair per cycle over a valid/ready handshake; results leave in order after a fixed latency.
- Propagates backpressure from the consumer.
- Serves as the general-purpose multiplier for datapath blocks that need widths above 4 bits and a registered, stallable interface.

## Interface
- WIDTH, 8, operand width in bits; legal range 4..32.
- STAGES, 2, number of pipeline register stages (latency in cycles); legal range 1..4.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair on a/b is valid.
- in_ready  output  1  block accepts the operand pair this cycle.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- is_signed  input  1  treat a and b as two's complement; sampled with a/b.
- out_valid  output  1  product is valid.
- out_ready  input  1  consumer accepts the product this cycle.
- product  output  2·WIDTH  result of the multiply.

## Operation
- **Accept rule:** a transaction is accepted when in_valid && in_ready. A result is consumed when out_valid && out_ready.
- **Unsigned result:** product = a·b, exact in 2·WIDTH bits.
- **Signed result:** when is_signed=1 and SIGNED_MODE_EN is defined, product = signed(a)·signed(b), exact two's complement in 2·WIDTH bits.
  - Uses Baugh-Wooley partial-product inversion plus correction constant.
- **Datapath structure:**
  - WIDTH² AND partial products.
  - Wallace reduction with full and half adders down to two rows.
  - Final carry-propagate adder.
- **Register placement:**
  - Stage 1 registers the partial-product array (or the operands when STAGES=1, where the whole tree and adder sit after the register).
  - Reduction layers are split as evenly as possible across the remaining stages.
  - The final adder precedes the last register.
- **Pipeline valid bits:** each stage carries a valid bit; product and out_valid come from the last stage.
- **Stall model:** global stall, stall = out_valid && !out_ready.
  - While stalled, every stage holds its contents.
  - in_ready = !stall.
- **Bubbles:** when not stalled, all stages advance every cycle; bubbles (valid=0) advance like data and are not collapsed.
- **Held output:** product is held stable while out_valid=1 and out_ready=0.
- **Idle output:** when out_valid=0, product holds its last value. Consumers ignore it.
- **Ordering:** results leave in acceptance order; nothing is dropped or duplicated.

## Timing
- **Reset:** rst=1 at a rising edge clears all stage valid bits and all data registers.
  - Afterwards out_valid=0, product=0, in_ready=1.
  - Effective from the first edge with rst=1.
  - rst has priority over every handshake in that cycle.
- **Reset mid-operation:** all in-flight transactions are discarded.
  - No product from before reset ever appears with out_valid=1.
  - An in_valid asserted during the rst=1 cycle is not accepted.
- **Latency:** operands accepted at edge k appear with out_valid=1 after edge k+STAGES-1, i.e. visible in the cycle following edge k+STAGES-1, given no stall in between. Each stall cycle adds one cycle.
- **Throughput:** one result per cycle with out_ready held high.
- **Simultaneous events:**
  - Consume and accept in the same cycle are always legal when out_ready=1.
  - in_ready is combinational from out_valid and out_ready only; it never depends on in_valid.
- **Clearing out_valid:** if out_valid=1, out_ready=1 and the previous stage holds a bubble, out_valid falls to 0 on the next edge.

## Configuration
- **Macro:** SIGNED_MODE_EN.
- **Defined:**
  - is_signed is honoured per transaction.
  - The is_signed bit is pipelined alongside the operands to select the Baugh-Wooley correction.
- **Undefined:**
  - is_signed is ignored and all products are unsigned.
  - No signed correction logic is built.
  - The is_signed port still exists so instantiations are identical.

## Test plan
- Reset with in_valid=1, rst=1 for 2 cycles, then rst=0 and in_valid=0 -> out_valid=0, product=16'h0000, in_ready=1 throughout and after.
- WIDTH=8, STAGES=2, unsigned 8'hFF×8'hFF, out_ready=1 -> product=16'hFE01 with out_valid=1 exactly 2 cycles after acceptance; 8'h0D×8'h0B -> 16'h008F.
- SIGNED_MODE_EN defined:
  - is_signed=1 gives 8'h80×8'h80 -> 16'h4000, 8'hFF×8'h02 -> 16'hFFFE, 8'h80×8'h7F -> 16'hC080.
  - Same operands with is_signed=0 give 16'h4000, 16'h01FE, 16'h3F80.
- Back-to-back stream of 100 random pairs with out_ready=1 -> 100 consecutive out_valid cycles, each matching a reference model, in order.
- Backpressure:
  - out_ready=0 for 5 cycles while a result is at the output -> product and out_valid constant, in_ready=0.
  - Further in_valid pairs are not accepted.
  - After release, all results arrive in order with no loss.
- Assert rst for 1 cycle with 2 transactions in flight -> out_valid stays 0 until a new transaction is accepted; its product appears STAGES cycles later.

Source files
------------

// File: rtl/wallace_mult_pipe.sv
// wallace_mult_pipe: pipelined Wallace-tree multiplier with valid/ready handshake.
// Optional signed (Baugh-Wooley) mode is built when SIGNED_MODE_EN is defined.
module wallace_mult_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
`ifdef SIGNED_MODE_EN
  localparam int NR = WIDTH + 1;
`else
  localparam int NR = WIDTH;
`endif

  typedef logic [NR-1:0][PW-1:0] rows_t;

  function automatic int rows_after(input int n);
    int c;
    c = NR;
    for (int i = 0; i < 16; i++)
      if (i < n) c = 2 * (c / 3) + c % 3;
    return c;
  endfunction

  function automatic int num_layers();
    int n;
    n = 0;
    for (int i = 0; i < 16; i++)
      if (rows_after(i) > 2) n = i + 1;
    return n;
  endfunction

  localparam int NL = num_layers();

  // One Wallace layer: each group of three rows becomes a sum and a
  // carry row; leftover rows pass straight through.
  function automatic rows_t csa_layer(input rows_t r, input int cnt);
    rows_t o;
    int g;
    o = '0;
    g = cnt / 3;
    for (int j = 0; j < NR / 3; j++)
      if (j < g) begin
        o[2*j]   = r[3*j] ^ r[3*j+1] ^ r[3*j+2];
        o[2*j+1] = ((r[3*j] & r[3*j+1])
                  | (r[3*j] & r[3*j+2])
                  | (r[3*j+1] & r[3*j+2])) << 1;
      end
    for (int m = 0; m < NR; m++)
      if (m >= 3 * g && m < cnt) o[m-g] = r[m];
    return o;
  endfunction

  function automatic rows_t reduce(input rows_t r, input int lo,
                                   input int hi);
    rows_t t;
    t = r;
    for (int i = 0; i < 16; i++)
      if (i >= lo && i < hi) t = csa_layer(t, rows_after(i));
    return t;
  endfunction

  // Signed rows invert the terms that mix exactly one sign bit; the
  // extra row adds the matching 2^W + 2^(2W-1) correction.
  function automatic rows_t pp_gen(input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y,
                                   input logic s);
    rows_t r;
    logic p;
    r = '0;
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++) begin
        p = x[j] & y[i];
        if (s && ((i == WIDTH-1) != (j == WIDTH-1))) p = ~p;
        r[i][i+j] = p;
      end
`ifdef SIGNED_MODE_EN
    if (s) r[WIDTH] = (PW'(1) << WIDTH) | (PW'(1) << (PW-1));
`endif
    return r;
  endfunction

  function automatic logic [PW-1:0] fin_add(input rows_t r);
    return r[0] + r[1];
  endfunction

  logic [STAGES-1:0] vld;
  logic              stall;
  logic              sgn;

`ifdef SIGNED_MODE_EN
  assign sgn = is_signed;
`else
  logic unused_sgn;
  assign unused_sgn = is_signed;
  assign sgn = 1'b0;
`endif

  assign out_valid = vld[STAGES-1];
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else if (!stall) begin
      vld[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) vld[i] <= vld[i-1];
    end
  end

  if (STAGES == 1) begin : g_one
    logic [WIDTH-1:0] a_q, b_q;
    logic             s_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        a_q <= '0;
        b_q <= '0;
        s_q <= 1'b0;
      end else if (in_valid && in_ready) begin
        a_q <= a;
        b_q <= b;
        s_q <= sgn;
      end
    end

    assign product = fin_add(reduce(pp_gen(a_q, b_q, s_q), 0, NL));
  end else begin : g_multi
    rows_t          st_q [STAGES-1];
    logic [PW-1:0]  prod_q;

    // Data registers load only behind a valid bit so idle output holds.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < STAGES - 1; i++) st_q[i] <= '0;
        prod_q <= '0;
      end else if (!stall) begin
        if (in_valid) st_q[0] <= pp_gen(a, b, sgn);
        for (int s = 1; s < STAGES - 1; s++)
          if (vld[s-1])
            st_q[s] <= reduce(st_q[s-1],
                              (s - 1) * NL / (STAGES - 1),
                              s * NL / (STAGES - 1));
        if (vld[STAGES-2])
          prod_q <= fin_add(reduce(st_q[STAGES-2],
                                   (STAGES - 2) * NL / (STAGES - 1),
                                   NL));
      end
    end

    assign product = prod_q;
  end

endmodule
